// File: rtl/uart_rx_fifo_if.sv
// Byte-queue bus between the UART receiver / CPU side (master) and the
// receive FIFO (slave).
interface uart_rx_fifo_if #(
  parameter int ADDR_W = 3
);
  logic              RX_STATUS;
  logic [7:0]        RX_DATA;
  logic              RD_EN;
  logic              CLR_OVF;
  logic [7:0]        RD_DATA;
  logic              EMPTY;
  logic              FULL;
  logic [ADDR_W:0]   COUNT;
  logic              OVERFLOW;

  modport master (
    output RX_STATUS, RX_DATA, RD_EN, CLR_OVF,
    input  RD_DATA, EMPTY, FULL, COUNT, OVERFLOW
  );

  modport slave (
    input  RX_STATUS, RX_DATA, RD_EN, CLR_OVF,
    output RD_DATA, EMPTY, FULL, COUNT, OVERFLOW
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through byte FIFO behind the UART receiver: one push per
// rising edge of the byte-done strobe, sticky overflow on dropped bytes.
module uart_rx_fifo #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic            sysclk,
  input  logic            reset,
  uart_rx_fifo_if.slave   bus
);

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

  logic [7:0]        mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              empty_q, empty_d;
  logic              full_q, full_d;
  logic              ovf_q, ovf_d;
  logic              rx_status_q;
  logic              armed_q, armed_d;

  logic              push_s;
  logic              pop_s;
  logic              wr_en_s;
  logic              drop_s;

  // armed_q stays low after reset until the strobe has been seen low, so a
  // byte still signalled while reset releases is not queued a second time.
  always_comb begin
    push_s   = bus.RX_STATUS & ~rx_status_q & armed_q;
    pop_s    = bus.RD_EN & ~empty_q;
    wr_en_s  = push_s & (~full_q | pop_s);
    drop_s   = push_s & full_q & ~pop_s;
    armed_d  = armed_q | ~bus.RX_STATUS;
    wr_ptr_d = wr_en_s ? wr_ptr_q + {{(ADDR_W-1){1'b0}}, 1'b1} : wr_ptr_q;
    rd_ptr_d = pop_s   ? rd_ptr_q + {{(ADDR_W-1){1'b0}}, 1'b1} : rd_ptr_q;
    case ({wr_en_s, pop_s})
      2'b10:   count_d = count_q + {{ADDR_W{1'b0}}, 1'b1};
      2'b01:   count_d = count_q - {{ADDR_W{1'b0}}, 1'b1};
      default: count_d = count_q;
    endcase
    empty_d = (count_d == {(ADDR_W+1){1'b0}});
    full_d  = (count_d == FULL_CNT);
    if (drop_s) begin
      ovf_d = 1'b1;
    end else if (bus.CLR_OVF) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // Pointers, occupancy, status flags and strobe history.
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q    <= {ADDR_W{1'b0}};
      rd_ptr_q    <= {ADDR_W{1'b0}};
      count_q     <= {(ADDR_W+1){1'b0}};
      empty_q     <= 1'b1;
      full_q      <= 1'b0;
      ovf_q       <= 1'b0;
      rx_status_q <= 1'b0;
      armed_q     <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      empty_q     <= empty_d;
      full_q      <= full_d;
      ovf_q       <= ovf_d;
      rx_status_q <= bus.RX_STATUS;
      armed_q     <= armed_d;
    end
  end

  // Storage array; contents survive reset and are masked by EMPTY.
  always_ff @(posedge sysclk) begin
    if (wr_en_s) begin
      mem_q[wr_ptr_q] <= bus.RX_DATA;
    end
  end

  assign bus.RD_DATA  = empty_q ? 8'h00 : mem_q[rd_ptr_q];
  assign bus.EMPTY    = empty_q;
  assign bus.FULL     = full_q;
  assign bus.COUNT    = count_q;
  assign bus.OVERFLOW = ovf_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: held strobes, fill/overflow, wrap,
// full and empty corners, and asynchronous reset mid-operation.
module tb_uart_rx_fifo;

  logic sysclk = 1'b0;
  logic reset  = 1'b0;
  int   n_cmp  = 0;
  int   n_err  = 0;

  uart_rx_fifo_if #(.ADDR_W(3)) bus ();

  uart_rx_fifo #(.DEPTH(8), .ADDR_W(3)) dut (
    .sysclk (sysclk),
    .reset  (reset),
    .bus    (bus)
  );

  always #5 sysclk = ~sysclk;

  task automatic tick();
    @(posedge sysclk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_byte(input logic [7:0] b);
    bus.RX_DATA   = b;
    bus.RX_STATUS = 1'b1;
    tick();
    bus.RX_STATUS = 1'b0;
    tick();
  endtask

  task automatic pop_check(input string tag, input logic [7:0] exp);
    check(tag, 32'(bus.RD_DATA), 32'(exp));
    bus.RD_EN = 1'b1;
    tick();
    bus.RD_EN = 1'b0;
  endtask

  initial begin
    bus.RX_STATUS = 1'b0;
    bus.RX_DATA   = 8'h00;
    bus.RD_EN     = 1'b0;
    bus.CLR_OVF   = 1'b0;
    #12;
    check("rst_count", 32'(bus.COUNT), 32'd0);
    check("rst_empty", 32'(bus.EMPTY), 32'd1);
    check("rst_full", 32'(bus.FULL), 32'd0);
    check("rst_ovf", 32'(bus.OVERFLOW), 32'd0);
    check("rst_rdata", 32'(bus.RD_DATA), 32'h00);
    reset = 1'b1;
    tick();
    tick();

    // 1: held strobe -> one push
    bus.RX_DATA   = 8'hA5;
    bus.RX_STATUS = 1'b1;
    tick();
    check("t1_count_first", 32'(bus.COUNT), 32'd1);
    check("t1_rdata", 32'(bus.RD_DATA), 32'hA5);
    for (int i = 0; i < 4; i++) tick();
    check("t1_count_held", 32'(bus.COUNT), 32'd1);
    check("t1_empty", 32'(bus.EMPTY), 32'd0);
    bus.RX_STATUS = 1'b0;
    tick();
    pop_check("t1_pop", 8'hA5);
    check("t1_empty_after", 32'(bus.EMPTY), 32'd1);
    check("t1_rdata_empty", 32'(bus.RD_DATA), 32'h00);

    // 2: fill, overflow, drain, clear
    for (int i = 1; i <= 8; i++) push_byte(8'(i));
    check("t2_full_pre", 32'(bus.FULL), 32'd1);
    check("t2_ovf_pre", 32'(bus.OVERFLOW), 32'd0);
    push_byte(8'h09);
    check("t2_full", 32'(bus.FULL), 32'd1);
    check("t2_count", 32'(bus.COUNT), 32'd8);
    check("t2_ovf", 32'(bus.OVERFLOW), 32'd1);
    for (int i = 1; i <= 8; i++) pop_check("t2_drain", 8'(i));
    check("t2_empty", 32'(bus.EMPTY), 32'd1);
    check("t2_ovf_sticky", 32'(bus.OVERFLOW), 32'd1);
    bus.CLR_OVF = 1'b1;
    tick();
    bus.CLR_OVF = 1'b0;
    check("t2_ovf_clr", 32'(bus.OVERFLOW), 32'd0);

    // 3: wrap-around
    for (int i = 0; i < 5; i++) push_byte(8'h10 + 8'(i));
    check("t3_count5", 32'(bus.COUNT), 32'd5);
    for (int i = 0; i < 5; i++) pop_check("t3_pop5", 8'h10 + 8'(i));
    for (int i = 5; i < 11; i++) push_byte(8'h10 + 8'(i));
    check("t3_count6", 32'(bus.COUNT), 32'd6);
    for (int i = 5; i < 11; i++) pop_check("t3_pop6", 8'h10 + 8'(i));
    check("t3_count0", 32'(bus.COUNT), 32'd0);
    check("t3_empty", 32'(bus.EMPTY), 32'd1);

    // 4: push and pop together at FULL
    for (int i = 1; i <= 8; i++) push_byte(8'(i));
    bus.RX_DATA   = 8'hFF;
    bus.RX_STATUS = 1'b1;
    bus.RD_EN     = 1'b1;
    tick();
    bus.RD_EN = 1'b0;
    check("t4_count", 32'(bus.COUNT), 32'd8);
    check("t4_full", 32'(bus.FULL), 32'd1);
    check("t4_ovf", 32'(bus.OVERFLOW), 32'd0);
    bus.RX_STATUS = 1'b0;
    tick();
    for (int i = 2; i <= 8; i++) pop_check("t4_drain", 8'(i));
    pop_check("t4_drain_ff", 8'hFF);
    check("t4_empty", 32'(bus.EMPTY), 32'd1);

    // 5: RD_EN while empty, then with a push
    bus.RD_EN = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t5_idle_count", 32'(bus.COUNT), 32'd0);
    end
    check("t5_idle_rdata", 32'(bus.RD_DATA), 32'h00);
    bus.RX_DATA   = 8'h3C;
    bus.RX_STATUS = 1'b1;
    tick();
    bus.RD_EN     = 1'b0;
    bus.RX_STATUS = 1'b0;
    check("t5_count", 32'(bus.COUNT), 32'd1);
    check("t5_rdata", 32'(bus.RD_DATA), 32'h3C);
    tick();
    pop_check("t5_pop", 8'h3C);

    // 6: async reset mid-operation, strobe held across release
    for (int i = 0; i < 9; i++) push_byte(8'h40 + 8'(i));
    for (int i = 0; i < 4; i++) pop_check("t6_pre_pop", 8'h40 + 8'(i));
    check("t6_pre_count", 32'(bus.COUNT), 32'd4);
    check("t6_pre_ovf", 32'(bus.OVERFLOW), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check("t6_rst_count", 32'(bus.COUNT), 32'd0);
    check("t6_rst_empty", 32'(bus.EMPTY), 32'd1);
    check("t6_rst_full", 32'(bus.FULL), 32'd0);
    check("t6_rst_ovf", 32'(bus.OVERFLOW), 32'd0);
    check("t6_rst_rdata", 32'(bus.RD_DATA), 32'h00);
    bus.RX_DATA   = 8'h55;
    bus.RX_STATUS = 1'b1;
    #2;
    reset = 1'b1;
    tick();
    tick();
    check("t6_held_nopush", 32'(bus.COUNT), 32'd0);
    bus.RX_STATUS = 1'b0;
    tick();
    push_byte(8'h77);
    check("t6_count", 32'(bus.COUNT), 32'd1);
    check("t6_rdata", 32'(bus.RD_DATA), 32'h77);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Byte buffer directly downstream of the UART receiver. It consumes the receiver's RX_STATUS/RX_DATA pair and queues each received byte exactly once. It presents the bytes to the CPU peripheral bus through a first-word-fall-through read port with EMPTY/FULL/COUNT status. It absorbs bursts while software is busy and flags bytes lost to overflow.

Parameters:
DEPTH, 8, number of byte entries; power of two, 2..64.
ADDR_W, 3, pointer width; log2(DEPTH).

Ports:
sysclk  input  1  system clock; all logic on rising edge.
reset  input  1  asynchronous, active-low reset.
RX_STATUS  input  1  receiver byte-done strobe; high for one or more sysclk cycles per byte.
RX_DATA  input  8  received byte; valid whenever RX_STATUS is high.
RD_EN  input  1  pop request from the CPU side, sampled at the sysclk edge.
CLR_OVF  input  1  clears OVERFLOW.
RD_DATA  output  8  head-of-queue byte (FWFT); 8'h00 when EMPTY.
EMPTY  output  1  queue holds 0 bytes.
FULL  output  1  queue holds DEPTH bytes.
COUNT  output  ADDR_W+1  number of bytes held, 0..DEPTH.
OVERFLOW  output  1  sticky: a byte arrived while full and was dropped.

Behaviour:
- Reset (reset=0, asynchronous): wr_ptr=0, rd_ptr=0, COUNT=0, EMPTY=1, FULL=0, OVERFLOW=0, RD_DATA=8'h00, rx_status_d=0. Memory contents are not reset.
- Strobe qualification:
  - RX_STATUS can stay high for several sysclk cycles because the receiver's bit counter runs on the slower tick clock.
  - push = RX_STATUS & ~rx_status_d, where rx_status_d is RX_STATUS registered on sysclk.
  - Exactly one push occurs per rising edge of RX_STATUS. RX_DATA is sampled in the push cycle.
- Write: on push & ~FULL, mem[wr_ptr] <= RX_DATA and wr_ptr increments modulo DEPTH.
- Write when full: on push & FULL with no effective pop, the byte is dropped, pointers are unchanged, and OVERFLOW <= 1.
- Read: pop = RD_EN & ~EMPTY. On pop, rd_ptr increments modulo DEPTH. RD_EN while EMPTY is ignored with no state change.
- FWFT: RD_DATA = mem[rd_ptr] combinationally whenever ~EMPTY. A written byte appears on RD_DATA the cycle after its push edge, i.e. one sysclk of latency from the push cycle.
- COUNT update:
  - push-only: +1.
  - pop-only: -1.
  - push and pop together: unchanged, with both pointers advancing.
  - EMPTY and FULL are decoded from the registered COUNT (COUNT==0, COUNT==DEPTH).
- Simultaneous push and pop when FULL: the pop frees a slot, so the write is accepted, COUNT stays DEPTH, and OVERFLOW is not set.
- Simultaneous push and RD_EN when EMPTY: the push is accepted and the pop is ignored. COUNT becomes 1.
- Pointer wrap-around: modulo DEPTH. Full and empty are distinguished by COUNT, never by pointer equality.
- OVERFLOW: set by a dropped byte and cleared by CLR_OVF. If a set and a clear occur in the same cycle, the set wins.
- Reset mid-operation: all queued bytes are discarded immediately and outputs return to reset values. A byte whose RX_STATUS is high as reset releases is not pushed unless RX_STATUS falls and rises again.
- No combinational path from RD_EN or RX_STATUS to any output other than through registers. RD_DATA depends only on rd_ptr and memory.

Test Plan:
1. Single byte, held strobe: RX_DATA=8'hA5, RX_STATUS high for 5 cycles -> exactly one push. Next cycle COUNT=1, EMPTY=0, RD_DATA=8'hA5. RD_EN for 1 cycle -> EMPTY=1, RD_DATA=8'h00.
2. Fill and overflow: push 8'h01..8'h08, then 8'h09 -> FULL=1, COUNT=8, OVERFLOW=1. Popping 8 times yields 8'h01..8'h08 in order. CLR_OVF -> OVERFLOW=0.
3. Wrap-around: push 5, pop 5, push 6, pop 6 with values 8'h10..8'h1A -> output order preserved across the pointer wrap and COUNT returns to 0.
4. Simultaneous push and pop at FULL: queue holds 8'h01..8'h08, push 8'hFF with RD_EN=1 in the same cycle -> COUNT stays 8, OVERFLOW stays 0. Draining yields 8'h02..8'h08, 8'hFF.
5. Empty corner: RD_EN=1 with the queue empty for 3 cycles -> no change. RD_EN=1 in the same cycle as a push of 8'h3C -> COUNT=1, RD_DATA=8'h3C.
6. Reset mid-operation: 4 bytes queued and OVERFLOW=1, assert reset asynchronously between clock edges -> all outputs reach reset values immediately. After release, the first push of 8'h77 gives COUNT=1, RD_DATA=8'h77.
